// File: rtl/vga_sync_to_stream.sv
// Converts VGA-timed pixels (active-low vs/hs/blank) into a valid-qualified
// stream with row/col coordinates, frame markers and sticky geometry error flags.
module vga_sync_to_stream #(
    parameter int unsigned WIDTH        = 640,
    parameter int unsigned HEIGHT       = 480,
    parameter int unsigned PIXEL_DEPTH  = 8,
    parameter int unsigned COORD_WIDTH  = 13,
    parameter int unsigned FCOUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    vs_ni,
    input  logic                    hs_ni,
    input  logic                    blank_ni,
    input  logic [PIXEL_DEPTH-1:0]  input_R,
    input  logic [PIXEL_DEPTH-1:0]  input_G,
    input  logic [PIXEL_DEPTH-1:0]  input_B,
    input  logic                    err_clr,
    output logic [PIXEL_DEPTH-1:0]  output_R,
    output logic [PIXEL_DEPTH-1:0]  output_G,
    output logic [PIXEL_DEPTH-1:0]  output_B,
    output logic                    valid,
    output logic [COORD_WIDTH-1:0]  row,
    output logic [COORD_WIDTH-1:0]  col,
    output logic                    sof,
    output logic                    eol,
    output logic                    eof,
    output logic                    line_err,
    output logic                    frame_err,
    output logic [FCOUNT_WIDTH-1:0] frame_count
);

    localparam logic [COORD_WIDTH-1:0] W_C    = COORD_WIDTH'(WIDTH);
    localparam logic [COORD_WIDTH-1:0] H_C    = COORD_WIDTH'(HEIGHT);
    localparam logic [COORD_WIDTH-1:0] W_LAST = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] H_LAST = COORD_WIDTH'(HEIGHT - 1);

    typedef enum logic {
        SYNC_WAIT,
        FRAME
    } state_t;

    state_t state, state_next;

    logic                    vs_prev, blank_prev;
    logic [COORD_WIDTH-1:0]  row_cnt, col_cnt;
    logic [COORD_WIDTH-1:0]  row_cnt_next, col_cnt_next, row_after_eol;

    logic [PIXEL_DEPTH-1:0]  r_next, g_next, b_next;
    logic                    valid_next, sof_next, eol_next, eof_next;
    logic [COORD_WIDTH-1:0]  row_next, col_next;
    logic                    line_set, frame_set;
    logic                    line_err_next, frame_err_next;
    logic [FCOUNT_WIDTH-1:0] fcount_next;

    logic vs_edge, blank_fall, accept;

    assign vs_edge    = vs_prev & ~vs_ni;
    assign blank_fall = blank_prev & ~blank_ni;
    assign accept     = blank_ni & vs_ni;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SYNC_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == SYNC_WAIT && vs_edge) begin
            state_next = FRAME;
        end
    end

    always_comb begin
        r_next         = output_R;
        g_next         = output_G;
        b_next         = output_B;
        valid_next     = 1'b0;
        row_next       = row;
        col_next       = col;
        sof_next       = 1'b0;
        eol_next       = 1'b0;
        eof_next       = 1'b0;
        row_cnt_next   = row_cnt;
        col_cnt_next   = col_cnt;
        row_after_eol  = row_cnt;
        fcount_next    = frame_count;
        line_set       = 1'b0;
        frame_set      = 1'b0;

        case (state)
            SYNC_WAIT: begin
                if (vs_edge) begin
                    row_cnt_next = '0;
                    col_cnt_next = '0;
                end
            end
            FRAME: begin
                if (accept) begin
                    if (!hs_ni) begin
                        frame_set = 1'b1;
                    end
                    if (col_cnt < W_C && row_cnt < H_C) begin
                        valid_next   = 1'b1;
                        r_next       = input_R;
                        g_next       = input_G;
                        b_next       = input_B;
                        row_next     = row_cnt;
                        col_next     = col_cnt;
                        sof_next     = (row_cnt == '0) && (col_cnt == '0);
                        eol_next     = (col_cnt == W_LAST);
                        eof_next     = (row_cnt == H_LAST) && (col_cnt == W_LAST);
                        col_cnt_next = col_cnt + 1'b1;
                    end else begin
                        col_cnt_next = (col_cnt < W_C) ? col_cnt + 1'b1 : W_C;
                        if (col_cnt >= W_C) begin
                            line_set = 1'b1;
                        end
                        if (row_cnt >= H_C) begin
                            frame_set = 1'b1;
                        end
                    end
                end

                // Line end is evaluated before the vs check so that a short
                // final line still counts toward the row total it reports.
                if (blank_fall) begin
                    if (col_cnt != W_C) begin
                        line_set = 1'b1;
                    end
                    row_after_eol = (row_cnt < H_C) ? row_cnt + 1'b1 : H_C;
                    row_cnt_next  = row_after_eol;
                    col_cnt_next  = '0;
                end

                if (vs_edge) begin
                    if (row_after_eol != H_C) begin
                        frame_set = 1'b1;
                    end else begin
                        fcount_next = frame_count + 1'b1;
                    end
                    row_cnt_next = '0;
                    col_cnt_next = '0;
                end
            end
            default: begin
            end
        endcase

        line_err_next  = line_set  | (line_err  & ~err_clr);
        frame_err_next = frame_set | (frame_err & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev     <= 1'b1;
            blank_prev  <= 1'b1;
            row_cnt     <= '0;
            col_cnt     <= '0;
            output_R    <= '0;
            output_G    <= '0;
            output_B    <= '0;
            valid       <= 1'b0;
            row         <= '0;
            col         <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            vs_prev     <= vs_ni;
            blank_prev  <= blank_ni;
            row_cnt     <= row_cnt_next;
            col_cnt     <= col_cnt_next;
            output_R    <= r_next;
            output_G    <= g_next;
            output_B    <= b_next;
            valid       <= valid_next;
            row         <= row_next;
            col         <= col_next;
            sof         <= sof_next;
            eol         <= eol_next;
            eof         <= eof_next;
            line_err    <= line_err_next;
            frame_err   <= frame_err_next;
            frame_count <= fcount_next;
        end
    end

endmodule

// File: tb/tb_vga_sync_to_stream.sv
// Directed bench for vga_sync_to_stream with an 8x4 frame geometry.
module tb_vga_sync_to_stream;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int PD     = 8;
    localparam int CW     = 13;
    localparam int FW     = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vs_ni, hs_ni, blank_ni, err_clr;
    logic [PD-1:0] input_R, input_G, input_B;
    logic [PD-1:0] output_R, output_G, output_B;
    logic          valid, sof, eol, eof, line_err, frame_err;
    logic [CW-1:0] row, col;
    logic [FW-1:0] frame_count;

    int checks = 0;
    int passes = 0;
    int nvalid = 0, nsof = 0, neol = 0, neof = 0;

    vga_sync_to_stream #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .PIXEL_DEPTH(PD),
        .COORD_WIDTH(CW),
        .FCOUNT_WIDTH(FW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .vs_ni(vs_ni),
        .hs_ni(hs_ni),
        .blank_ni(blank_ni),
        .input_R(input_R),
        .input_G(input_G),
        .input_B(input_B),
        .err_clr(err_clr),
        .output_R(output_R),
        .output_G(output_G),
        .output_B(output_B),
        .valid(valid),
        .row(row),
        .col(col),
        .sof(sof),
        .eol(eol),
        .eof(eof),
        .line_err(line_err),
        .frame_err(frame_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pr(input int r, input int c);
        return 8'(r * 16 + c + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int r, input int c);
        input_R = pr(r, c);
        input_G = pr(r, c) ^ 8'hFF;
        input_B = pr(r, c) ^ 8'h3C;
    endtask

    task automatic vs_pulse();
        blank_ni = 1'b0;
        vs_ni    = 1'b0;
        tick();
        vs_ni    = 1'b1;
        tick();
    endtask

    // Drives n active pixels for row r, checking each output cycle; optionally
    // closes the line with three blank cycles.
    task automatic send_line(input int r, input int n, input bit close, input int hs_pos);
        for (int c = 0; c < n; c++) begin
            blank_ni = 1'b1;
            hs_ni    = (c == hs_pos) ? 1'b0 : 1'b1;
            set_pix(r, c);
            tick();
            if (c < WIDTH) begin
                chk("valid", 32'(valid), 32'd1);
                chk("row", 32'(row), r);
                chk("col", 32'(col), c);
                chk("R", 32'(output_R), 32'(pr(r, c)));
                chk("G", 32'(output_G), 32'(pr(r, c) ^ 8'hFF));
                chk("B", 32'(output_B), 32'(pr(r, c) ^ 8'h3C));
                chk("sof", 32'(sof), 32'(r == 0 && c == 0));
                chk("eol", 32'(eol), 32'(c == WIDTH - 1));
                chk("eof", 32'(eof), 32'(r == HEIGHT - 1 && c == WIDTH - 1));
            end else begin
                chk("ovf_valid", 32'(valid), 32'd0);
                chk("ovf_col_hold", 32'(col), WIDTH - 1);
                chk("ovf_R_hold", 32'(output_R), 32'(pr(r, WIDTH - 1)));
                chk("ovf_eol", 32'(eol), 32'd0);
            end
            nvalid += int'(valid);
            nsof   += int'(sof);
            neol   += int'(eol);
            neof   += int'(eof);
        end
        hs_ni = 1'b1;
        if (close) begin
            blank_ni = 1'b0;
            tick();
            chk("blank_valid", 32'(valid), 32'd0);
            chk("blank_eol", 32'(eol), 32'd0);
            chk("blank_row_hold", 32'(row), r);
            chk("blank_col_hold", 32'(col), (n < WIDTH) ? n - 1 : WIDTH - 1);
            tick();
            tick();
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        vs_ni    = 1'b1;
        hs_ni    = 1'b1;
        blank_ni = 1'b0;
        err_clr  = 1'b0;
        input_R  = '0;
        input_G  = '0;
        input_B  = '0;
        tick();
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_lerr", 32'(line_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset_n = 1'b1;

        // Active pixels before any vs are ignored.
        for (int i = 0; i < 5; i++) begin
            blank_ni = 1'b1;
            set_pix(2, i);
            tick();
            chk("presync_valid", 32'(valid), 32'd0);
        end
        blank_ni = 1'b0;
        tick();
        chk("presync_lerr", 32'(line_err), 32'd0);
        chk("presync_ferr", 32'(frame_err), 32'd0);

        // Clean frame.
        vs_pulse();
        nvalid = 0; nsof = 0; neol = 0; neof = 0;
        for (int r = 0; r < HEIGHT; r++) send_line(r, WIDTH, 1'b1, -1);
        vs_pulse();
        chk("clean_nvalid", nvalid, 32);
        chk("clean_nsof", nsof, 1);
        chk("clean_neol", neol, 4);
        chk("clean_neof", neof, 1);
        chk("clean_fc", 32'(frame_count), 32'd1);
        chk("clean_lerr", 32'(line_err), 32'd0);
        chk("clean_ferr", 32'(frame_err), 32'd0);
        chk("clean_row_hold", 32'(row), 32'd3);
        chk("clean_col_hold", 32'(col), 32'd7);

        // Long line on row 1.
        send_line(0, WIDTH, 1'b1, -1);
        send_line(1, 10, 1'b1, -1);
        chk("long_lerr", 32'(line_err), 32'd1);
        chk("long_ferr", 32'(frame_err), 32'd0);
        send_line(2, WIDTH, 1'b1, -1);
        send_line(3, WIDTH, 1'b1, -1);
        vs_pulse();
        chk("long_fc", 32'(frame_count), 32'd2);
        chk("long_ferr_end", 32'(frame_err), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_lerr", 32'(line_err), 32'd0);

        // Short frame: three lines then vs.
        for (int r = 0; r < 3; r++) send_line(r, WIDTH, 1'b1, -1);
        vs_pulse();
        chk("short_ferr", 32'(frame_err), 32'd1);
        chk("short_fc", 32'(frame_count), 32'd2);
        chk("short_lerr", 32'(line_err), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("short_clr_ferr", 32'(frame_err), 32'd0);
        chk("short_clr_lerr", 32'(line_err), 32'd0);

        // Set wins over clear on a short line end.
        send_line(0, 5, 1'b0, -1);
        blank_ni = 1'b0;
        err_clr  = 1'b1;
        tick();
        err_clr  = 1'b0;
        chk("setwins_lerr", 32'(line_err), 32'd1);
        chk("setwins_ferr", 32'(frame_err), 32'd0);
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwins_clr", 32'(line_err), 32'd0);

        // Mid-frame reset at row 2.
        send_line(1, WIDTH, 1'b1, -1);
        send_line(2, 3, 1'b0, -1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_row", 32'(row), 32'd0);
        chk("mrst_col", 32'(col), 32'd0);
        chk("mrst_R", 32'(output_R), 32'd0);
        chk("mrst_G", 32'(output_G), 32'd0);
        chk("mrst_B", 32'(output_B), 32'd0);
        chk("mrst_sof", 32'(sof), 32'd0);
        chk("mrst_eol", 32'(eol), 32'd0);
        chk("mrst_fc", 32'(frame_count), 32'd0);
        tick();
        chk("mrst_hold_valid", 32'(valid), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            blank_ni = 1'b1;
            set_pix(2, i + 3);
            tick();
            chk("post_rst_valid", 32'(valid), 32'd0);
        end
        blank_ni = 1'b0;
        tick();
        vs_pulse();
        chk("post_rst_fc", 32'(frame_count), 32'd0);
        chk("post_rst_ferr", 32'(frame_err), 32'd0);

        // hs low during active video flags frame_err; pixels still pass.
        send_line(0, WIDTH, 1'b1, 2);
        chk("hs_ferr", 32'(frame_err), 32'd1);
        chk("hs_lerr", 32'(line_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
